muldiv_hilo_ctrl: RTL and testbench
===================================

# muldiv_hilo_ctrl

Execute-stage issue controller for the multi-cycle integer divider, and owner of the architectural HI/LO register pair. It accepts decoded multiply/divide/move-to-HI/LO operations from the pipeline and performs MULT/MULTU and MTHI/MTLO in a single cycle. For DIV/DIVU it launches the divider with a one-cycle request pulse, stalls the pipeline until the divider finishes, and captures the 64-bit {remainder, quotient} result into HI/LO.

## Interface
- No parameters. Data width is fixed at 32 bits.
- clk  in  1  Clock; all state updates on the rising edge.
- rst_n  in  1  Reset, asynchronous, active-low.
- flush  in  1  Pipeline flush. Also wired by the top level to the divider's flush input.
- op_valid  in  1  Operation present in EX. Held, with its operands, for as long as stall_out is high.
- op  in  3  Operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NOP.
- rs_val  in  32  Dividend, multiplicand, or MTHI/MTLO source.
- rt_val  in  32  Divisor or multiplier.
- stall_out  out  1  Holds the pipeline.
- hi  out  32  Registered HI.
- lo  out  32  Registered LO.
- div_valid  out  1  Registered start request to the divider.
- div_sign  out  1  Registered; 1 = signed divide.
- div_a  out  32  Registered dividend.
- div_b  out  32  Registered divisor.
- div_stall  in  1  Divider busy. Rises the cycle after the divider samples div_valid and stays high for exactly 32 cycles.
- div_result  in  64  Divider output: [63:32] remainder, [31:0] quotient. Stable from the first cycle div_stall is low after a run until the next start.

## Operation
- The state machine has three states: IDLE, ISSUE, WAIT.
- Operations are accepted only when the state is IDLE, op_valid=1 and flush=0.
  - MULT: {hi,lo} <= signed(rs_val) × signed(rt_val), full 64-bit product.
  - MULTU: {hi,lo} <= unsigned product, full 64-bit.
  - MTHI: hi <= rs_val. MTLO: lo <= rs_val.
  - These four complete at the end of the accepting cycle. No stall, state stays IDLE.
  - DIV/DIVU with rt_val != 0: div_a <= rs_val, div_b <= rt_val, div_sign <= (op==DIV), div_valid <= 1; go to ISSUE.
  - DIV/DIVU with rt_val == 0: no issue, hi/lo unchanged, no stall (completes like a NOP).
- ISSUE lasts one cycle with div_valid=1; the divider samples it at this cycle's closing edge. Next: div_valid <= 0, go to WAIT.
- WAIT:
  - While div_stall=1: hold.
  - First cycle with div_stall=0: hi <= div_result[63:32], lo <= div_result[31:0]; go to IDLE.
- div_valid is high for exactly one cycle per divide. It must never be high in IDLE or WAIT, because a held-high valid re-launches the divider.
- flush=1 in any state: next state IDLE, div_valid <= 0, no HI/LO write that cycle (flush wins over completion and acceptance).
- Reset values: state IDLE, hi=0, lo=0, div_valid=0, div_sign=0, div_a=0, div_b=0.
  - stall_out is combinational and therefore 0 in reset.

## Timing
- stall_out = !flush & ((IDLE & op_valid & op∈{DIV,DIVU} & rt_val!=0) | ISSUE | (WAIT & div_stall)).
- Divide, with cycle 0 being the accepting cycle:
  - cycle 1 is ISSUE.
  - cycles 2–33 are WAIT with div_stall=1.
  - cycle 34 is WAIT with div_stall=0: stall_out=0, and HI/LO are written at the end of cycle 34.
  - stall_out is therefore high for exactly 34 cycles (cycles 0–33).
  - The next instruction is presented in cycle 35 and may itself be a divide.
- hi/lo are visible one cycle after the write edge; no internal forwarding.
- Back-to-back MULT/MTHI/MTLO complete one per cycle.

## Test plan
- Reset: assert rst_n=0 mid-cycle, then release → hi=0, lo=0, div_valid=0, stall_out=0 immediately and after release.
- DIVU rs=100, rt=7:
  - stall_out high 34 cycles and div_valid high exactly 1 cycle (cycle 1).
  - lo=14, hi=2 visible in cycle 35.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Follow back-to-back with DIVU 0xFFFFFFF9/2 → lo=0x7FFFFFFC, hi=1.
- MULT rs=0xFFFFFFFF, rt=2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE. Then MULTU with the same operands → hi=1, lo=0xFFFFFFFE. No stall cycles on either.
- DIVU 50/5 with flush=1 in cycle 12 (WAIT):
  - state is IDLE in cycle 13, stall_out=0, hi/lo unchanged.
  - A following DIVU 9/4 gives lo=2, hi=1.
- DIV rs=5, rt=0 → no div_valid, stall_out=0, hi/lo unchanged. Then MTHI 0xA5A5A5A5, MTLO 0x5A5A5A5A → hi/lo take those values on consecutive cycles.

Source files
------------

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: HI/LO owner and issue/stall controller for the multi-cycle divider
module muldiv_hilo_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall_out,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_valid,
  output logic        div_sign,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_stall,
  input  logic [63:0] div_result
);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, nxt;
  logic        is_div, div_req, accept, start, wb_div;
  logic [63:0] prod_s, prod_u;
  logic [31:0] hi_n, lo_n;
  assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
  assign div_req = (state == IDLE) && op_valid && is_div && (rt_val != 32'd0);
  assign accept  = (state == IDLE) && op_valid && !flush;
  assign start   = div_req && !flush;
  assign wb_div  = !flush && (state == WAIT) && !div_stall;
  assign prod_s  = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u  = {32'd0, rs_val} * {32'd0, rt_val};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = flush ? IDLE :
          (state == IDLE)  ? (start ? ISSUE : IDLE) :
          (state == ISSUE) ? WAIT :
          (div_stall ? WAIT : IDLE);
  end
  always_comb begin
    stall_out = !flush && (div_req || (state == ISSUE) || ((state == WAIT) && div_stall));
  end
  always_comb begin
    hi_n = wb_div ? div_result[63:32] :
           !accept ? hi :
           (op == OP_MULT)  ? prod_s[63:32] :
           (op == OP_MULTU) ? prod_u[63:32] :
           (op == OP_MTHI)  ? rs_val : hi;
    lo_n = wb_div ? div_result[31:0] :
           !accept ? lo :
           (op == OP_MULT)  ? prod_s[31:0] :
           (op == OP_MULTU) ? prod_u[31:0] :
           (op == OP_MTLO)  ? rs_val : lo;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi        <= 32'd0;
      lo        <= 32'd0;
      div_valid <= 1'b0;
      div_sign  <= 1'b0;
      div_a     <= 32'd0;
      div_b     <= 32'd0;
    end else begin
      hi        <= hi_n;
      lo        <= lo_n;
      div_valid <= start;
      if (start) begin
        div_a    <= rs_val;
        div_b    <= rt_val;
        div_sign <= (op == OP_DIV);
      end
    end
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl: directed checks of muldiv_hilo_ctrl against a behavioural divider
module tb_muldiv_hilo_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        stall_out, div_valid, div_sign;
  logic [31:0] hi, lo, div_a, div_b;
  logic        div_stall;
  logic [63:0] div_result = 64'd0;
  logic [5:0]  cnt = 6'd0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] h0, l0;

  muldiv_hilo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .stall_out(stall_out), .hi(hi), .lo(lo),
    .div_valid(div_valid), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
    .div_stall(div_stall), .div_result(div_result)
  );

  always #5 clk = ~clk;

  assign div_stall = (cnt != 6'd0);

  always_ff @(posedge clk) begin
    if (flush) cnt <= 6'd0;
    else if (div_valid) begin
      cnt <= 6'd32;
      if (div_sign)
        div_result <= {32'($signed(div_a) % $signed(div_b)), 32'($signed(div_a) / $signed(div_b))};
      else
        div_result <= {div_a % div_b, div_a / div_b};
    end else if (cnt != 6'd0) cnt <= cnt - 6'd1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = (o != 3'd0);
    op = o;
    rs_val = a;
    rt_val = b;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input string tag, output logic [31:0] ph, output logic [31:0] pl);
    int ns = 0, nv = 0, vc = -1;
    ph = 32'd0;
    pl = 32'd0;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (c == 0) begin
        ph = hi;
        pl = lo;
      end
      if (stall_out) ns++;
      if (div_valid) begin
        nv++;
        vc = c;
      end
      next_cycle();
    end
    chk({tag, "_stall_cycles"}, 64'(ns), 64'd34);
    chk({tag, "_valid_cycles"}, 64'(nv), 64'd1);
    chk({tag, "_valid_at"}, 64'(vc), 64'd1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_div_valid", 64'(div_valid), 64'd0);
    chk("rst_stall", 64'(stall_out), 64'd0);
    #19 rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("post_rst_hi", 64'(hi), 64'd0);
    chk("post_rst_lo", 64'(lo), 64'd0);
    chk("post_rst_div_valid", 64'(div_valid), 64'd0);
    chk("post_rst_stall", 64'(stall_out), 64'd0);
    next_cycle();

    set_op(3'd4, 32'd100, 32'd7);
    run_div("divu_100_7", h0, l0);
    set_op(3'd3, 32'hFFFFFFF9, 32'd2);
    run_div("div_m7_2", h0, l0);
    chk("divu_100_7_hi", 64'(h0), 64'd2);
    chk("divu_100_7_lo", 64'(l0), 64'd14);
    set_op(3'd4, 32'hFFFFFFF9, 32'd2);
    run_div("divu_big_2", h0, l0);
    chk("div_m7_2_hi", 64'(h0), 64'hFFFFFFFF);
    chk("div_m7_2_lo", 64'(l0), 64'hFFFFFFFD);

    set_op(3'd1, 32'hFFFFFFFF, 32'd2);
    @(negedge clk);
    chk("divu_big_2_hi", 64'(hi), 64'd1);
    chk("divu_big_2_lo", 64'(lo), 64'h7FFFFFFC);
    chk("mult_stall", 64'(stall_out), 64'd0);
    next_cycle();
    set_op(3'd2, 32'hFFFFFFFF, 32'd2);
    @(negedge clk);
    chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo), 64'hFFFFFFFE);
    chk("multu_stall", 64'(stall_out), 64'd0);
    next_cycle();
    set_op(3'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("multu_hi", 64'(hi), 64'd1);
    chk("multu_lo", 64'(lo), 64'hFFFFFFFE);
    next_cycle();

    set_op(3'd4, 32'd50, 32'd5);
    for (int c = 0; c < 12; c++) next_cycle();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 64'(stall_out), 64'd0);
    next_cycle();
    flush = 1'b0;
    set_op(3'd4, 32'd9, 32'd4);
    run_div("divu_9_4", h0, l0);
    chk("flush_hi_kept", 64'(h0), 64'd1);
    chk("flush_lo_kept", 64'(l0), 64'hFFFFFFFE);

    set_op(3'd3, 32'd5, 32'd0);
    @(negedge clk);
    chk("divu_9_4_hi", 64'(hi), 64'd1);
    chk("divu_9_4_lo", 64'(lo), 64'd2);
    chk("div0_stall", 64'(stall_out), 64'd0);
    next_cycle();
    set_op(3'd5, 32'hA5A5A5A5, 32'd0);
    @(negedge clk);
    chk("div0_valid", 64'(div_valid), 64'd0);
    chk("div0_stall_after", 64'(stall_out), 64'd0);
    chk("div0_hi_kept", 64'(hi), 64'd1);
    chk("div0_lo_kept", 64'(lo), 64'd2);
    next_cycle();
    set_op(3'd6, 32'h5A5A5A5A, 32'd0);
    @(negedge clk);
    chk("mthi_hi", 64'(hi), 64'hA5A5A5A5);
    chk("mthi_lo_kept", 64'(lo), 64'd2);
    next_cycle();
    set_op(3'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("mtlo_hi_kept", 64'(hi), 64'hA5A5A5A5);
    chk("mtlo_lo", 64'(lo), 64'h5A5A5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
